// File: rtl/gpr_pkg.sv
// Package for the tiny16 general-purpose register file.
// Holds the default geometry, the named register indices and the default stack bounds.
package gpr_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;

    localparam int REG_PC = 0;
    localparam int REG_SP = 1;
    localparam int REG_R2 = 2;
    localparam int REG_R3 = 3;
    localparam int REG_R4 = 4;
    localparam int REG_R5 = 5;
    localparam int REG_R6 = 6;
    localparam int REG_R7 = 7;

    localparam logic [15:0] DEF_SP_RESET = 16'h00FF;
    localparam logic [15:0] DEF_SP_LIMIT = 16'h0080;

endpackage

// File: rtl/gpr_file_if.sv
// Bus bundle between the decoder/sequencer (master) and the register file (slave).
interface gpr_file_if
    import gpr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS
) ();

    localparam int SELW = $clog2(NREGS);

    logic [SELW-1:0]  rd_a_sel;
    logic [SELW-1:0]  rd_b_sel;
    logic [SELW-1:0]  wr_sel;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             pc_inc;
    logic             sp_push;
    logic             sp_pop;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] sp;
    logic             sp_err;

    modport master (
        output rd_a_sel, rd_b_sel, wr_sel, wr_en, wr_data, pc_inc, sp_push, sp_pop,
        input  rd_a, rd_b, pc, sp, sp_err
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, wr_sel, wr_en, wr_data, pc_inc, sp_push, sp_pop,
        output rd_a, rd_b, pc, sp, sp_err
    );

endinterface

// File: rtl/sp_unit.sv
// Stack-pointer stepping unit: bounded push/pop next-value logic plus the sticky fault flag.
// A push stops at SP_LIMIT (full) and a pop stops at SP_RESET (empty); hitting either sets the flag.
module sp_unit
    import gpr_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(DEF_SP_RESET),
    parameter logic [WIDTH-1:0] SP_LIMIT = WIDTH'(DEF_SP_LIMIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sp,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_spWrite,
    output logic [WIDTH-1:0] o_spNext,
    output logic             o_spErr
);

    logic w_errSet;
    logic r_spErr;

    // Next SP and fault pulse; push and pop together cancel out with no fault.
    always_comb begin
        o_spNext = i_sp;
        w_errSet = 1'b0;
        if (i_push && !i_pop) begin
            if (i_sp > SP_LIMIT) begin
                o_spNext = i_sp - 1'b1;
            end else begin
                w_errSet = 1'b1;
            end
        end else if (i_pop && !i_push) begin
            if (i_sp < SP_RESET) begin
                o_spNext = i_sp + 1'b1;
            end else begin
                w_errSet = 1'b1;
            end
        end
    end

    // Sticky fault flag; a direct write to SP suppresses the check for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spErr <= 1'b0;
        end else if (w_errSet && !i_spWrite) begin
            r_spErr <= 1'b1;
        end
    end

    assign o_spErr = r_spErr;

endmodule

// File: rtl/gpr_file.sv
// Parametrised register file for tiny16: two combinational read ports, one write port,
// auto-incrementing PC and bounded SP.
// Optional feature macro GPR_FILE_BYPASS_EN: forwards same-cycle write data to rd_a/rd_b.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               NREGS    = DEF_NREGS,
    parameter int               PC_IDX   = REG_PC,
    parameter int               SP_IDX   = REG_SP,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(DEF_SP_RESET),
    parameter logic [WIDTH-1:0] SP_LIMIT = WIDTH'(DEF_SP_LIMIT)
) (
    input  logic      clk,
    input  logic      rst,
    gpr_file_if.slave bus
);

    localparam int              SELW   = $clog2(NREGS);
    localparam logic [SELW-1:0] PC_SEL = SELW'(PC_IDX);
    localparam logic [SELW-1:0] SP_SEL = SELW'(SP_IDX);

    logic [WIDTH-1:0] r_regs     [NREGS];
    logic [WIDTH-1:0] w_regsNext [NREGS];
    logic [WIDTH-1:0] w_spNext;
    logic             w_spWrite;

    assign w_spWrite = bus.wr_en && (bus.wr_sel == SP_SEL);

    sp_unit #(
        .WIDTH    (WIDTH),
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_spUnit (
        .clk       (clk),
        .rst       (rst),
        .i_sp      (r_regs[SP_SEL]),
        .i_push    (bus.sp_push),
        .i_pop     (bus.sp_pop),
        .i_spWrite (w_spWrite),
        .o_spNext  (w_spNext),
        .o_spErr   (bus.sp_err)
    );

    // Per-register next state: a write wins over PC increment or stack stepping.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_regsNext[i] = r_regs[i];
            if (bus.wr_en && (bus.wr_sel == SELW'(i))) begin
                w_regsNext[i] = bus.wr_data;
            end else if (i == PC_IDX) begin
                if (bus.pc_inc) begin
                    w_regsNext[i] = r_regs[i] + 1'b1;
                end
            end else if (i == SP_IDX) begin
                w_regsNext[i] = w_spNext;
            end
        end
    end

    // Register storage; reset clears everything except SP, which returns to the empty-stack value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end else begin
                r_regs[i] <= w_regsNext[i];
            end
        end
    end

    // Read ports, optionally forwarding the in-flight write to a matching index.
    always_comb begin
        bus.rd_a = r_regs[bus.rd_a_sel];
        bus.rd_b = r_regs[bus.rd_b_sel];
`ifdef GPR_FILE_BYPASS_EN
        if (bus.wr_en && (bus.rd_a_sel == bus.wr_sel)) begin
            bus.rd_a = bus.wr_data;
        end
        if (bus.wr_en && (bus.rd_b_sel == bus.wr_sel)) begin
            bus.rd_b = bus.wr_data;
        end
`else
`endif
    end

    assign bus.pc = r_regs[PC_SEL];
    assign bus.sp = r_regs[SP_SEL];

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file with a behavioural model of the register file.
module tb_gpr_file;
    import gpr_pkg::*;

    localparam logic [15:0] SP_RST = 16'h00FF;
    localparam logic [15:0] SP_LIM = 16'h0080;

    logic clk;
    logic rst;

    gpr_file_if #(.WIDTH(16), .NREGS(8)) bus ();

    gpr_file #(
        .WIDTH    (16),
        .NREGS    (8),
        .PC_IDX   (0),
        .SP_IDX   (1),
        .SP_RESET (SP_RST),
        .SP_LIMIT (SP_LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errorCount = 0;
    int checkCount = 0;

    logic [15:0] model [8];
    bit          modelErr;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected combinational read, including same-cycle forwarding when enabled.
    function automatic logic [15:0] expRead(input logic [2:0] sel, input bit we,
                                            input logic [2:0] ws, input logic [15:0] wd);
`ifdef GPR_FILE_BYPASS_EN
        if (we && sel == ws) return wd;
`else
        if (we && sel == ws && 1'b0) return wd;
`endif
        return model[sel];
    endfunction

    // Model of one clock edge: compute stack/PC effects, then let a write land on top.
    task automatic modelStep(input bit r, input bit we, input logic [2:0] ws, input logic [15:0] wd,
                             input bit pi, input bit pu, input bit po);
        logic [15:0] nxt [8];
        bit fault;
        if (r) begin
            foreach (model[i]) model[i] = 16'h0000;
            model[1] = SP_RST;
            modelErr = 1'b0;
            return;
        end
        foreach (model[i]) nxt[i] = model[i];
        fault = 1'b0;
        if (pi) nxt[0] = model[0] + 16'd1;
        if (pu && !po) begin
            if (model[1] > SP_LIM) nxt[1] = model[1] - 16'd1;
            else fault = 1'b1;
        end
        if (po && !pu) begin
            if (model[1] < SP_RST) nxt[1] = model[1] + 16'd1;
            else fault = 1'b1;
        end
        if (we) begin
            nxt[ws] = wd;
            if (ws == 3'd1) fault = 1'b0;
        end
        foreach (model[i]) model[i] = nxt[i];
        if (fault) modelErr = 1'b1;
    endtask

    // Drive one cycle of inputs, check reads before and after the edge, advance the model.
    task automatic applyStimulus(input bit r, input bit we, input logic [2:0] ws, input logic [15:0] wd,
                                 input bit pi, input bit pu, input bit po,
                                 input logic [2:0] as, input logic [2:0] bs);
        rst = r;
        bus.wr_en = we;
        bus.wr_sel = ws;
        bus.wr_data = wd;
        bus.pc_inc = pi;
        bus.sp_push = pu;
        bus.sp_pop = po;
        bus.rd_a_sel = as;
        bus.rd_b_sel = bs;
        #1;
        if (!r) begin
            checkOutput("rdA_pre", bus.rd_a, expRead(as, we, ws, wd));
            checkOutput("rdB_pre", bus.rd_b, expRead(bs, we, ws, wd));
        end
        @(posedge clk);
        modelStep(r, we, ws, wd, pi, pu, po);
        #1;
        if (!r) begin
            checkOutput("rdA", bus.rd_a, expRead(as, we, ws, wd));
            checkOutput("rdB", bus.rd_b, expRead(bs, we, ws, wd));
        end
        checkOutput("pc", bus.pc, model[0]);
        checkOutput("sp", bus.sp, model[1]);
        checkOutput("spErr", bus.sp_err, modelErr);
    endtask

    // Read back every register through both ports with the bus idle.
    task automatic checkAllRegs();
        rst = 1'b0;
        bus.wr_en = 1'b0;
        bus.pc_inc = 1'b0;
        bus.sp_push = 1'b0;
        bus.sp_pop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rd_a_sel = 3'(i);
            bus.rd_b_sel = 3'(7 - i);
            #1;
            checkOutput($sformatf("regA%0d", i), bus.rd_a, model[i]);
            checkOutput($sformatf("regB%0d", 7 - i), bus.rd_b, model[7 - i]);
        end
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [15:0] wd;
        logic [2:0]  ws;
        foreach (model[i]) model[i] = 16'hxxxx;
        modelErr = 1'b0;

        // Reset defaults
        doReset();
        doReset();
        checkOutput("rst_pc", bus.pc, 16'h0000);
        checkOutput("rst_sp", bus.sp, 16'h00FF);
        checkOutput("rst_err", bus.sp_err, 1'b0);
        checkAllRegs();

        // Write r3 and read it back
        applyStimulus(0, 1, 3'd3, 16'h1234, 0, 0, 0, 3'd3, 3'd2);
        applyStimulus(0, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd3, 3'd3);
        checkOutput("r3_val", bus.rd_a, 16'h1234);

        // PC wrap and write-over-increment
        applyStimulus(0, 1, 3'd0, 16'hFFFF, 0, 0, 0, 3'd0, 3'd1);
        applyStimulus(0, 0, 3'd0, 16'h0000, 1, 0, 0, 3'd0, 3'd1);
        checkOutput("pc_wrap", bus.pc, 16'h0000);
        applyStimulus(0, 1, 3'd0, 16'h0040, 1, 0, 0, 3'd0, 3'd1);
        checkOutput("pc_wr_over_inc", bus.pc, 16'h0040);

        // Pop at empty stack, then error stays through valid pushes
        doReset();
        applyStimulus(0, 0, 3'd0, 16'h0000, 0, 0, 1, 3'd1, 3'd0);
        checkOutput("pop_empty_sp", bus.sp, 16'h00FF);
        checkOutput("pop_empty_err", bus.sp_err, 1'b1);
        repeat (3) applyStimulus(0, 0, 3'd0, 16'h0000, 0, 1, 0, 3'd1, 3'd0);
        checkOutput("err_sticky", bus.sp_err, 1'b1);

        // Fill the stack to its limit, then overflow
        doReset();
        repeat (127) applyStimulus(0, 0, 3'd0, 16'h0000, 0, 1, 0, 3'd1, 3'd2);
        checkOutput("full_sp", bus.sp, 16'h0080);
        checkOutput("full_err", bus.sp_err, 1'b0);
        applyStimulus(0, 0, 3'd0, 16'h0000, 0, 1, 0, 3'd1, 3'd2);
        checkOutput("ovf_sp", bus.sp, 16'h0080);
        checkOutput("ovf_err", bus.sp_err, 1'b1);

        // Push and pop together; write to SP overrides push
        doReset();
        applyStimulus(0, 0, 3'd0, 16'h0000, 0, 1, 1, 3'd1, 3'd0);
        checkOutput("pushpop_sp", bus.sp, 16'h00FF);
        checkOutput("pushpop_err", bus.sp_err, 1'b0);
        applyStimulus(0, 1, 3'd1, 16'h0090, 0, 1, 0, 3'd1, 3'd0);
        checkOutput("spwr_sp", bus.sp, 16'h0090);
        checkOutput("spwr_err", bus.sp_err, 1'b0);

        // Reset discards in-flight operations
        applyStimulus(0, 1, 3'd5, 16'hBEEF, 1, 0, 0, 3'd5, 3'd0);
        applyStimulus(1, 1, 3'd5, 16'h5555, 1, 1, 0, 3'd5, 3'd0);
        checkOutput("rstmid_pc", bus.pc, 16'h0000);
        checkOutput("rstmid_sp", bus.sp, 16'h00FF);
        checkOutput("rstmid_err", bus.sp_err, 1'b0);
        checkAllRegs();

        // Randomised traffic, biased so SP writes land near the bounds
        for (int n = 0; n < 400; n++) begin
            ws = 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            if (ws == 3'd1) begin
                case ($urandom_range(0, 2))
                    0: wd = 16'($urandom_range(16'h007E, 16'h0083));
                    1: wd = 16'($urandom_range(16'h00FB, 16'h0101));
                    default: ;
                endcase
            end
            if (ws == 3'd0 && $urandom_range(0, 3) == 0) wd = 16'hFFFF;
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 2) == 0), ws, wd,
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 2) == 0),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if (n % 50 == 49) checkAllRegs();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
